// File: rtl/fpdivsqrt_seq_pkg.sv
// Shared types and helpers for the FP divide/sqrt sequencer.
package fpu_divsqrt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } statetype;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;
  localparam logic PREC_DP = 1'b0;
  localparam logic PREC_SP = 1'b1;

  function automatic int iter_count(input logic op_type, input logic prec,
                                    input int div_dp, input int div_sp,
                                    input int sqrt_extra);
    int n;
    n = (prec == PREC_SP) ? div_sp : div_dp;
    if (op_type == OP_SQRT) n = n + sqrt_extra;
    return n;
  endfunction

endpackage

// File: rtl/fpdivsqrt_seq_if.sv
// Issue-side request and completion handshake of the divide/sqrt sequencer.
interface fpdivsqrt_seq_if #(
  parameter int TAGW = 5
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_op_type;
  logic            req_prec;
  logic [TAGW-1:0] req_tag;
  logic            resp_valid;
  logic            resp_ready;
  logic [TAGW-1:0] resp_tag;

  modport master (
    output req_valid, req_op_type, req_prec, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_tag
  );

  modport slave (
    input  req_valid, req_op_type, req_prec, req_tag, resp_ready,
    output req_ready, resp_valid, resp_tag
  );
endinterface

// File: rtl/fpdivsqrt_seq_itercnt.sv
// Loadable iteration down-counter; reports a 0-based up index and a last flag.
module fpdivsqrt_itercnt #(
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [CNTW-1:0] n,
  input  logic            en,
  output logic [CNTW-1:0] idx,
  output logic            last
);

  logic [CNTW-1:0] top_q;
  logic [CNTW-1:0] rem_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      top_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      top_q <= n - CNTW'(1);
      rem_q <= n - CNTW'(1);
    end else if (en && (rem_q != '0)) begin
      rem_q <= rem_q - CNTW'(1);
    end
  end

  assign idx  = top_q - rem_q;
  assign last = (rem_q == '0);

endmodule

// File: rtl/fpdivsqrt_seq.sv
// Control sequencer for the iterative FP divide/sqrt datapath: load, iterate,
// round, then hold a tagged completion until the consumer takes it.
module fpdivsqrt_seq
  import fpu_divsqrt_pkg::*;
#(
  parameter int DIV_ITER_DP = 4,
  parameter int DIV_ITER_SP = 3,
  parameter int SQRT_EXTRA  = 1,
  parameter int TAGW        = 5,
  parameter int CNTW        = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  fpdivsqrt_seq_if.slave  bus,
  output logic            dp_load,
  output logic            dp_op_type,
  output logic            dp_prec,
  output logic            dp_iter_en,
  output logic [CNTW-1:0] dp_iter_cnt,
  output logic            dp_round_en,
  output logic            busy
);

  localparam int MAX_ITER =
    ((DIV_ITER_DP > DIV_ITER_SP) ? DIV_ITER_DP : DIV_ITER_SP) + SQRT_EXTRA;

  if ((2 ** CNTW) <= MAX_ITER) begin : g_cntw_check
    $error("CNTW too narrow for the largest iteration count");
  end

  statetype        state, state_n;
  logic            accept;
  logic            op_q, prec_q;
  logic [TAGW-1:0] tag_q;
  logic [CNTW-1:0] n_iter, idx;
  logic            last;

  assign n_iter = CNTW'(iter_count(op_q, prec_q, DIV_ITER_DP, DIV_ITER_SP, SQRT_EXTRA));

  fpdivsqrt_itercnt #(.CNTW(CNTW)) u_itercnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == LOAD),
    .n       (n_iter),
    .en      (state == ITER),
    .idx     (idx),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= OP_DIV;
      prec_q <= PREC_DP;
      tag_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= bus.req_op_type;
        prec_q <= bus.req_prec;
        tag_q  <= bus.req_tag;
      end
    end
  end

  // Flush outranks everything, including a completion handshake in DONE.
  always_comb begin
    state_n       = state;
    bus.req_ready = ~flush & ((state == IDLE) | ((state == DONE) & bus.resp_ready));
    accept        = bus.req_valid & bus.req_ready;
    case (state)
      IDLE:    if (accept) state_n = LOAD;
      LOAD:    state_n = ITER;
      ITER:    if (last) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE: begin
        if (accept)              state_n = LOAD;
        else if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  assign dp_load        = (state == LOAD);
  assign dp_iter_en     = (state == ITER);
  assign dp_round_en    = (state == ROUND);
  assign dp_iter_cnt    = (state == ITER) ? idx : '0;
  assign dp_op_type     = op_q;
  assign dp_prec        = prec_q;
  assign busy           = (state != IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_tag   = tag_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!bus.resp_valid || state == DONE);
      assert (state != ITER || idx < n_iter);
    end
  end

endmodule

// File: tb/tb_fpdivsqrt_seq.sv
// Directed bench for fpdivsqrt_seq with a tag scoreboard on completions.
module tb_fpdivsqrt_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       dp_load, dp_op_type, dp_prec, dp_iter_en, dp_round_en, busy;
  logic [2:0] dp_iter_cnt;
  logic [4:0] ctl;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] sb[$];

  fpdivsqrt_seq_if #(.TAGW(5)) bus ();

  fpdivsqrt_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .bus         (bus),
    .dp_load     (dp_load),
    .dp_op_type  (dp_op_type),
    .dp_prec     (dp_prec),
    .dp_iter_en  (dp_iter_en),
    .dp_iter_cnt (dp_iter_cnt),
    .dp_round_en (dp_round_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign ctl = {dp_load, dp_iter_en, dp_round_en, bus.resp_valid, busy};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request from IDLE or DONE, expects it accepted, checks LOAD.
  task automatic issue(input logic op, input logic prec, input logic [4:0] tag);
    bus.req_valid   = 1'b1;
    bus.req_op_type = op;
    bus.req_prec    = prec;
    bus.req_tag     = tag;
    #1;
    chk("req_ready_accept", 32'(bus.req_ready), 32'd1);
    sb.push_back(tag);
    tick();
    bus.req_valid = 1'b0;
    chk("load_ctl", 32'(ctl), 32'b10001);
    chk("load_op", 32'(dp_op_type), 32'(op));
    chk("load_prec", 32'(dp_prec), 32'(prec));
  endtask

  task automatic follow(input int n, input logic [4:0] tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("iter_ctl", 32'(ctl), 32'b01001);
      chk("iter_cnt", 32'(dp_iter_cnt), 32'(i));
    end
    tick();
    chk("round_ctl", 32'(ctl), 32'b00101);
    tick();
    chk("done_ctl", 32'(ctl), 32'b00011);
    chk("done_tag", 32'(bus.resp_tag), 32'(tag));
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.resp_valid && bus.resp_ready && !flush) begin
      if (sb.size() == 0) chk("sb_unexpected_resp", 32'(sb.size()), 32'd1);
      else                chk("sb_resp_tag", 32'(bus.resp_tag), 32'(sb.pop_front()));
    end
  end

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op_type = 1'b0;
    bus.req_prec    = 1'b0;
    bus.req_tag     = '0;
    bus.resp_ready  = 1'b1;
    tick();
    tick();
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_cnt", 32'(dp_iter_cnt), 32'd0);
    chk("rst_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_op", 32'(dp_op_type), 32'd0);
    chk("rst_prec", 32'(dp_prec), 32'd0);
    reset_n = 1'b1;
    tick();

    // DP divide, N = 4, single-cycle completion
    issue(1'b0, 1'b0, 5'h0A);
    follow(4, 5'h0A);
    tick();
    chk("dpdiv_idle_after", 32'(ctl), 32'd0);

    // SP sqrt, N = 3 + 1
    issue(1'b1, 1'b1, 5'h03);
    follow(4, 5'h03);
    tick();
    chk("spsqrt_idle_after", 32'(ctl), 32'd0);

    // Backpressure in DONE, then back-to-back accept
    bus.resp_ready = 1'b0;
    issue(1'b1, 1'b0, 5'h11);
    follow(5, 5'h11);
    bus.req_valid   = 1'b1;
    bus.req_op_type = 1'b0;
    bus.req_prec    = 1'b1;
    bus.req_tag     = 5'h12;
    #1;
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_hold_ctl", 32'(ctl), 32'b00011);
      chk("bp_hold_tag", 32'(bus.resp_tag), 32'h11);
      chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    issue(1'b0, 1'b1, 5'h12);
    follow(3, 5'h12);
    tick();
    chk("b2b_idle_after", 32'(ctl), 32'd0);

    // Flush mid-ITER at cnt = 2
    issue(1'b0, 1'b0, 5'h15);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_iter_cnt", 32'(dp_iter_cnt), 32'(i));
    end
    flush = 1'b1;
    void'(sb.pop_back());
    tick();
    chk("fl_idle_ctl", 32'(ctl), 32'd0);
    flush = 1'b0;
    issue(1'b0, 1'b1, 5'h16);
    follow(3, 5'h16);
    tick();
    chk("fl_next_idle", 32'(ctl), 32'd0);

    // Async reset pulse ignored, then synchronous reset in ROUND
    issue(1'b1, 1'b1, 5'h07);
    tick();
    chk("rs_iter_cnt0", 32'(dp_iter_cnt), 32'd0);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("rs_pulse_ctl", 32'(ctl), 32'b01001);
    chk("rs_pulse_cnt", 32'(dp_iter_cnt), 32'd1);
    tick();
    tick();
    chk("rs_iter_cnt3", 32'(dp_iter_cnt), 32'd3);
    tick();
    chk("rs_round_ctl", 32'(ctl), 32'b00101);
    void'(sb.pop_back());
    reset_n = 1'b0;
    tick();
    chk("rs_ctl", 32'(ctl), 32'd0);
    chk("rs_tag", 32'(bus.resp_tag), 32'd0);
    chk("rs_op", 32'(dp_op_type), 32'd0);
    chk("rs_prec", 32'(dp_prec), 32'd0);
    reset_n = 1'b1;
    tick();

    // Flush and resp_ready together in DONE with a pending request
    bus.resp_ready = 1'b0;
    issue(1'b0, 1'b0, 5'h1C);
    follow(4, 5'h1C);
    flush           = 1'b1;
    bus.resp_ready  = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_op_type = 1'b1;
    bus.req_prec    = 1'b1;
    bus.req_tag     = 5'h1D;
    #1;
    chk("fd_req_ready", 32'(bus.req_ready), 32'd0);
    void'(sb.pop_back());
    tick();
    chk("fd_idle_ctl", 32'(ctl), 32'd0);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    chk("fd_no_accept", 32'(ctl), 32'd0);
    chk("fd_op_unchanged", 32'(dp_op_type), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpdivsqrt_seq.md
Name: fpdivsqrt_seq

Overview:
Sequencer for the iterative FP divide/square-root datapath. It accepts one operation at a time from the FPU issue stage and drives the datapath controls: operand load through the precision-conversion stage, iteration enables and count, and the rounding step. It returns a tagged completion with valid/ready backpressure and supports pipeline flush. The block holds no arithmetic state; the datapath holds all operand and result registers.

Parameters:
- DIV_ITER_DP, 4, iteration cycles for double-precision divide.
- DIV_ITER_SP, 3, iteration cycles for single-precision divide.
- SQRT_EXTRA, 1, extra iteration cycles added for sqrt at either precision.
- TAGW, 5, width of the destination tag carried through the operation.
- CNTW, 3, iteration counter width; must satisfy 2^CNTW > max(DIV_ITER_DP, DIV_ITER_SP) + SQRT_EXTRA.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, reset.
- req_valid, in, 1, issue stage presents an operation.
- req_ready, out, 1, sequencer accepts the operation this cycle.
- req_op_type, in, 1, 0 = divide, 1 = sqrt.
- req_prec, in, 1, 0 = double, 1 = single (P convention).
- req_tag, in, TAGW, destination tag.
- flush, in, 1, kill any in-flight operation.
- dp_load, out, 1, datapath captures converted Float1/Float2b this cycle.
- dp_op_type, out, 1, latched op type sent to the conversion stage and iteration logic.
- dp_prec, out, 1, latched precision.
- dp_iter_en, out, 1, datapath performs one iteration step.
- dp_iter_cnt, out, CNTW, index of the current iteration (0-based).
- dp_round_en, out, 1, datapath performs the round/normalise step.
- resp_valid, out, 1, result in the datapath register is final.
- resp_ready, in, 1, consumer takes the result.
- resp_tag, out, TAGW, tag of the completing operation.
- busy, out, 1, high whenever state != IDLE.

Behaviour:
- Single clock. Reset is synchronous and active-low: reset_n = 0 sampled at posedge clk resets the block. Reset overrides every other input, including mid-operation.
- Reset values:
  - state = IDLE.
  - All outputs 0: dp_iter_cnt = 0, resp_tag = 0, dp_op_type = 0, dp_prec = 0.
- States: IDLE, LOAD, ITER, ROUND, DONE. All outputs except req_ready are decoded from registered state.
- Accept condition:
  - req_ready = ~flush & (state == IDLE | (state == DONE & resp_ready)).
  - On req_valid & req_ready: latch op_type, prec and tag; go to LOAD.
- LOAD: dp_load = 1 for exactly one cycle. Computes N:
  - divide: DIV_ITER_DP if prec = 0, DIV_ITER_SP if prec = 1.
  - sqrt: the divide value plus SQRT_EXTRA.
  - Next state is ITER with cnt = 0.
- ITER: dp_iter_en = 1 and dp_iter_cnt = cnt. cnt increments each cycle; when cnt == N-1, go to ROUND.
- ROUND: dp_round_en = 1 for one cycle; next state is DONE.
- DONE: resp_valid = 1 and resp_tag is held stable until resp_ready.
  - resp_ready with a new accept in the same cycle: go to LOAD (back-to-back issue).
  - resp_ready without a new accept: go to IDLE.
  - resp_ready = 0: hold in DONE.
- Latency: with acceptance at edge E0, resp_valid is first high after edge E0 + N + 2. Example: DP divide gives N = 4, so resp_valid rises 6 edges after acceptance.
- Flush:
  - flush = 1 at any edge forces state to IDLE with no response.
  - Flush in DONE while resp_ready = 1: flush wins and the response is dropped. The consumer must qualify handshakes with ~flush.
  - Flush in IDLE together with req_valid: the request is not accepted, because req_ready = 0.
- dp_op_type and dp_prec are stable from LOAD through DONE and change only on accept. This makes a mid-operation change on req_* lines harmless.
- dp_iter_en, dp_load and dp_round_en are mutually exclusive (one-hot with IDLE/DONE).
- Assertions:
  - No resp_valid in any state other than DONE.
  - cnt never exceeds N-1.
  - The CNTW sizing rule holds at elaboration.

Decomposition:
- Shared package fpu_divsqrt_pkg holds:
  - the state enum (statetype: IDLE, LOAD, ITER, ROUND, DONE);
  - localparams OP_DIV = 0, OP_SQRT = 1, PREC_DP = 0, PREC_SP = 1;
  - an iteration-count function of (op_type, prec, params).
- A single sub-module, fpdivsqrt_itercnt, holds the loadable down-counter. It takes load/N/en and outputs the index and a last flag.

Test Plan:
- DP divide: req_valid with op_type = 0, prec = 0, tag = 5'h0A at edge 0, resp_ready = 1. Required: dp_load in cycle 1; dp_iter_en in cycles 2–5 with cnt 0,1,2,3; dp_round_en in cycle 6; resp_valid with tag 0x0A in cycle 7, for one cycle.
- SP sqrt: op_type = 1, prec = 1. Required: exactly 4 iteration cycles (3+1), cnt 0..3, and resp_valid 6 cycles after the load cycle.
- Backpressure: resp_ready = 0 for 3 cycles in DONE. Required: resp_valid and resp_tag held, req_ready = 0. When resp_ready rises with req_valid = 1, the new op is accepted the same cycle, LOAD follows, and there is no IDLE bubble.
- Flush mid-ITER (cnt = 2). Required: IDLE next edge, busy = 0, no resp_valid ever for that tag. A request in the following cycle is accepted normally.
- Reset_n = 0 during ROUND. Required: next edge gives IDLE with all outputs 0. An asynchronous reset_n pulse between edges must produce no state change.
- Flush and resp_ready together in DONE, with req_valid = 1. Required: req_ready = 0, next state IDLE, no accept.
